load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access initiator between the CPU execute stage and `data_memory`. Accepts one load or store request per transaction over a valid/ready handshake and converts byte addresses to word indices. Performs byte/halfword loads with sign or zero extension, and implements sub-word stores as read-modify-write, because the memory port is word-only. Returns one response per request: load data or error.

## Interface
- `DEPTH_LOG2`, 10: log2 of memory depth in words; word index = `req_addr[DEPTH_LOG2+1:2]`, zero-extended to 32 bits.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; request accepted on a rising edge with `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle response strobe.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  request rejected; qualified by `resp_valid`.
- `mem_read`  out  1  memory read enable.
- `mem_write`  out  1  memory write enable; memory writes on the `clk` edge.
- `mem_address`  out  32  word index.
- `mem_write_data`  out  32  word to write.
- `mem_read_data`  in  32  combinational read word from memory.

## Operation
- States: IDLE, LOAD, RMW, STORE, RESP. `req_ready` = 1 only in IDLE.
- On accept, latch all request fields and drive `mem_address` from the latched address.
- Transitions out of IDLE on accept:
  - error condition → RESP with `resp_error` = 1;
  - load → LOAD;
  - word store → STORE, with the write word = `req_wdata`;
  - byte/half store → RMW.
- Error conditions: `req_size` = 11 always; misalignment only under the Configuration macro.
- LOAD: `mem_read` = 1.
  - At the edge, select the lane from `mem_read_data`, extend it, register it into `resp_rdata`, then → RESP.
- RMW: `mem_read` = 1.
  - At the edge, merge the low byte/half of `req_wdata` into the read word at the addressed lane, then → STORE.
- STORE: `mem_write` = 1, `mem_write_data` = write word, then → RESP.
- RESP: `resp_valid` = 1 for exactly one cycle, then → IDLE.
- Lanes are little-endian:
  - byte k = `addr[1:0]` occupies bits [8k+7:8k];
  - half h = `addr[1]` occupies bits [16h+15:16h].
- `mem_read` and `mem_write` are never both 1. Both are 0 in IDLE and RESP.
- `mem_address` and `mem_write_data` hold their last values when idle.

## Timing
- Latency from accept edge to the `resp_valid` cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- A new request can be accepted at the edge ending RESP + 1, i.e. the first IDLE cycle. Throughput is one transaction per 3–4 cycles.
- Reset is asynchronous and active-high. While `reset` is asserted:
  - state = IDLE;
  - `req_ready`, `resp_valid`, `resp_error`, `mem_read`, `mem_write` = 0;
  - `resp_rdata`, `mem_address`, `mem_write_data` = 0.
- Reset mid-transaction aborts it: no write is issued if reset arrives before STORE, and no response is produced.
- `req_valid` while `req_ready` = 0 is ignored. The requester holds it.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, causes an error response. No memory access occurs.
- Not defined: low address bits beyond the access size are ignored.
  - Half uses lane `addr[1]`.
  - Word uses the whole word.
  - `resp_error` is set only for `req_size` = 11.

## Test plan
- Memory initialised RAM[i] = i.
  - Word load at 0x10 → `mem_address` = 4 while `mem_read` = 1; `resp_rdata` = 0x00000004, `resp_valid` 2 cycles after accept.
- Byte store 0xAB at 0x21 (RAM[8] = 0x00000008) → RMW read, then write 0x0000AB08.
  - Follow-up LBU at 0x21 → 0x000000AB.
  - Follow-up LB at 0x21 → 0xFFFFFFAB.
- Word store 0x80011234 at 0x30:
  - LH at 0x32 → 0xFFFF8001;
  - LHU at 0x32 → 0x00008001;
  - LB at 0x30 → 0x00000034.
- Word load at 0x13:
  - with `LSU_MISALIGN_TRAP_EN` → `resp_error` = 1 one cycle after accept, `mem_read` never asserted;
  - without it → `resp_rdata` = 0x00000004, `resp_error` = 0.
- Reset asserted in the RMW state of a byte store to 0x40 → `mem_write` never pulses, all outputs 0, and a later word load at 0x40 returns 0x00000010. `req_ready` = 1 on the first edge after release.
- `req_valid` held high with two back-to-back loads → the second is accepted only in the IDLE cycle after the first response. Exactly two `resp_valid` pulses.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: valid/ready load/store initiator in front of a word-only data memory.
// Sub-word stores are read-modify-write; define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW, STORE, RESP} state_t;

  state_t      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic        lat_unsigned;
  logic [15:0] lat_wdata;

  logic        accept;
  logic        req_error;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        unused_addr_bits;

  assign accept           = req_valid && req_ready;
  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    req_error = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0])            req_error = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_error = 1'b1;
`endif
  end

  // Lane extraction/merge work off the latched request and the combinational memory word.
  always_comb begin
    lane_byte = mem_read_data[{lat_lane, 3'b000} +: 8];
    lane_half = lat_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (lat_size)
      2'b00:   load_data = {{24{lane_byte[7] & ~lat_unsigned}}, lane_byte};
      2'b01:   load_data = {{16{lane_half[15] & ~lat_unsigned}}, lane_half};
      default: load_data = mem_read_data;
    endcase

    merged_word = mem_read_data;
    if (lat_size == 2'b00) merged_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    else                   merged_word[{lat_lane[1], 4'b0000} +: 16] = lat_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      lat_size       <= '0;
      lat_lane       <= '0;
      lat_unsigned   <= 1'b0;
      lat_wdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready    <= 1'b0;
            lat_size     <= req_size;
            lat_lane     <= req_addr[1:0];
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata[15:0];
            mem_address  <= 32'(req_addr[DEPTH_LOG2+1:2]);
            if (req_error) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write) begin
              state    <= LOAD;
              mem_read <= 1'b1;
            end else if (req_size == 2'b10) begin
              state          <= STORE;
              mem_write      <= 1'b1;
              mem_write_data <= req_wdata;
            end else begin
              state    <= RMW;
              mem_read <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOAD: begin
          mem_read   <= 1'b0;
          resp_rdata <= load_data;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RMW: begin
          mem_read       <= 1'b0;
          mem_write      <= 1'b1;
          mem_write_data <= merged_word;
          state          <= STORE;
        end
        STORE: begin
          mem_write  <= 1'b0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural word RAM plus an expected-response scoreboard.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] ram [0:1023];

  int   vectors = 0, miscompares = 0;
  int   cyc = 0, acc_total = 0, last_acc = 0;
  int   rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, both_cnt = 0;
  logic [31:0] last_rd_addr = '0;
  exp_t sb [$];
  int   acc_q [$];

  always #5 clk = ~clk;

  load_store_unit #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = ram[mem_address[9:0]];
  always @(posedge clk) if (mem_write) ram[mem_address[9:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      last_acc = cyc;
      acc_total++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (mem_read && mem_write) both_cnt++;
    if (mem_read) begin rd_cnt++; last_rd_addr = mem_address; end
    if (mem_write) wr_cnt++;
    if (resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) check("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        check("rdata", resp_rdata, e.rdata);
        check("error", {31'b0, resp_error}, {31'b0, e.err});
        check("latency", cyc - a + 1, e.lat);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      check("resp_timeout", sb.size(), 32'd0);
      sb.delete();
      acc_q.delete();
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
    wait_ready();
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    sb.push_back('{exp_d, exp_e, exp_lat});
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_resp_error"}, {31'b0, resp_error}, 32'd0);
    check({tag, "_mem_read"}, {31'b0, mem_read}, 32'd0);
    check({tag, "_mem_write"}, {31'b0, mem_write}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_mem_address"}, mem_address, 32'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    int n, r0, t0, a0, rd0, wr0;
    for (int i = 0; i < 1024; i++) ram[i] = i;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;

    #22;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Word load and address translation
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0004, 1'b0, 2);
    check("lw_mem_address", last_rd_addr, 32'd4);

    // Byte store via RMW, then signed/unsigned byte loads
    issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AB, 32'h0, 1'b0, 3);
    check("sb_ram8", ram[8], 32'h0000_AB08);
    issue(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, 32'h0000_00AB, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'hFFFF_FFAB, 1'b0, 2);

    // Word store, then half/byte loads from it
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h8001_1234, 32'h0, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'hFFFF_8001, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'h0000_8001, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'h0000_0034, 1'b0, 2);

    // Half store to upper lane and byte store to lane 3
    issue(1'b1, 2'b01, 1'b0, 32'h46, 32'h1234_BEEF, 32'h0, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hBEEF_0011, 1'b0, 2);
    issue(1'b1, 2'b00, 1'b0, 32'h4B, 32'hFFFF_FF7F, 32'h0, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 32'h7F00_0012, 1'b0, 2);

    // Misaligned word load
    rd0 = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
    check("misalign_no_read", rd_cnt, rd0);
`else
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0000_0004, 1'b0, 2);
    check("misalign_read", rd_cnt, rd0 + 1);
`endif

    // Illegal size: load and store both error with no memory traffic
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b1, 1);
    check("illegal_no_read", rd_cnt, rd0);
    check("illegal_no_write", wr_cnt, wr0);
    check("illegal_ram4", ram[4], 32'h0000_0004);

    // Reset during RMW of a byte store aborts it
    wait_ready();
    r0 = resp_cnt;
    req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_reading", {31'b0, mem_read}, 32'd1);
    wr0 = wr_cnt;
    #1 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    @(posedge clk); #1;
    check("ready_after_abort", {31'b0, req_ready}, 32'd1);
    check("abort_no_write", wr_cnt, wr0);
    check("abort_no_resp", resp_cnt, r0);
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0000_0010, 1'b0, 2);

    // Back-to-back loads with req_valid held high
    wait_ready();
    r0 = resp_cnt; t0 = acc_total;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = '0;
    req_valid = 1'b1;
    sb.push_back('{32'h0, 1'b0, 2});
    @(posedge clk); #1;
    a0 = last_acc;
    req_addr = 32'h4;
    sb.push_back('{32'h1, 1'b0, 2});
    n = 0;
    while (acc_total < t0 + 2 && n < 10) begin @(posedge clk); #1; n++; end
    req_valid = 1'b0;
    check("b2b_accepts", acc_total, t0 + 2);
    check("b2b_gap", last_acc - a0, 32'd3);
    drain();
    repeat (3) @(negedge clk);
    check("b2b_resp_pulses", resp_cnt - r0, 32'd2);

    check("rd_wr_exclusive", both_cnt, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
